fb_port_arbiter: RTL and testbench

//  Sole owner of the single-port frame-buffer SRAM. Shares it between the VGA

---
 rtl/fb_port_arbiter.sv | 105 ++++++++++
 tb/tb_fb_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// Frame-buffer SRAM port arbiter: display scan-out reads always win the single
// port; a valid/ack pixel writer gets the remaining cycles.
module fb_port_arbiter #(
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 8,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int WR_BLANK_ONLY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_pulse,
  input  logic [9:0]        col,
  input  logic [9:0]        row,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              frame_done
);

  localparam logic [ADDR_W:0]   PIX_COUNT = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic {SYNC_WAIT, RUN} frame_state_t;
  typedef enum logic [1:0] {PORT_IDLE, PORT_READ, PORT_WRITE, PORT_REJECT} port_state_t;

  frame_state_t      frame_state_reg, frame_state_next;
  port_state_t       port_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next, rd_addr_cur;
  logic              rd_pipe_reg;
  logic              frame_start, active, disp, wr_blocked, wr_in_range;

  always_comb begin
    frame_start      = pixel_pulse && (col == 10'd0) && (row == 10'd0);
    active           = (32'(col) < H_ACTIVE) && (32'(row) < V_ACTIVE);
    disp             = ((frame_state_reg == RUN) || frame_start) && pixel_pulse && active;
    wr_blocked       = (WR_BLANK_ONLY != 0) && active;
    wr_in_range      = {1'b0, wr_addr} < PIX_COUNT;
    // Frame start re-anchors the scan address so a slipped frame realigns.
    rd_addr_cur      = frame_start ? '0 : rd_addr_reg;

    frame_state_next = frame_state_reg;
    if (frame_start)
      frame_state_next = RUN;

    rd_addr_next = rd_addr_reg;
    if (disp)
      rd_addr_next = (rd_addr_cur == LAST_ADDR) ? '0 : rd_addr_cur + 1'b1;
    else if (frame_start)
      rd_addr_next = '0;

    // A request still visible while its ack is out has already been consumed.
    port_next = PORT_IDLE;
    if (disp)
      port_next = PORT_READ;
    else if (wr_req && !wr_ack && !wr_blocked)
      port_next = wr_in_range ? PORT_WRITE : PORT_REJECT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_state_reg <= SYNC_WAIT;
      rd_addr_reg     <= '0;
      rd_pipe_reg     <= 1'b0;
      wr_ack          <= 1'b0;
      wr_err          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      pix_data        <= '0;
      pix_valid       <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      frame_state_reg <= frame_state_next;
      rd_addr_reg     <= rd_addr_next;
      mem_re          <= (port_next == PORT_READ);
      mem_we          <= (port_next == PORT_WRITE);
      wr_ack          <= (port_next == PORT_WRITE) || (port_next == PORT_REJECT);
      wr_err          <= (port_next == PORT_REJECT);
      frame_done      <= (port_next == PORT_READ) && (rd_addr_cur == LAST_ADDR);
      if (port_next == PORT_READ) begin
        mem_addr <= rd_addr_cur;
      end else if (port_next == PORT_WRITE) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
      // SRAM data is valid the cycle after mem_re; capture it one cycle later.
      rd_pipe_reg <= mem_re;
      pix_valid   <= rd_pipe_reg;
      if (rd_pipe_reg)
        pix_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: two instances (writes anywhere / blanking only)
// on a shrunken raster, checked cycle by cycle against a raster-level model.
module tb_fb_port_arbiter;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int HT = 20;
  localparam int VT = 10;
  localparam int HV = H * V;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_pulse;
  logic [9:0]  col, row;
  logic        wr_req    [2];
  logic [18:0] wr_addr   [2];
  logic [7:0]  wr_data   [2];
  logic        wr_ack    [2];
  logic        wr_err    [2];
  logic [18:0] mem_addr  [2];
  logic [7:0]  mem_wdata [2];
  logic        mem_we    [2];
  logic        mem_re    [2];
  logic [7:0]  mem_rdata [2];
  logic [7:0]  pix_data  [2];
  logic        pix_valid [2];
  logic        frame_done[2];

  int vectors = 0;
  int miscompares = 0;

  // Model state: what each instance should be showing right now.
  bit          running;
  bit          e_re[2], e_we[2], e_ack[2], e_err[2], e_fd[2], e_pv[2];
  logic [18:0] e_addr[2];
  logic [7:0]  e_wdata[2], e_pd[2];
  bit          re_hist[2];
  logic [18:0] addr_hist[2];
  bit          ack_prev[2];
  int          reads_in_frame;

  always #5 clk = ~clk;

  fb_port_arbiter #(.ADDR_W(19), .DATA_W(8), .H_ACTIVE(H), .V_ACTIVE(V), .WR_BLANK_ONLY(0)) u_any (
    .clk(clk), .rst(rst), .pixel_pulse(pixel_pulse), .col(col), .row(row),
    .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .wr_ack(wr_ack[0]), .wr_err(wr_err[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]), .mem_re(mem_re[0]),
    .mem_rdata(mem_rdata[0]), .pix_data(pix_data[0]), .pix_valid(pix_valid[0]),
    .frame_done(frame_done[0]));

  fb_port_arbiter #(.ADDR_W(19), .DATA_W(8), .H_ACTIVE(H), .V_ACTIVE(V), .WR_BLANK_ONLY(1)) u_blank (
    .clk(clk), .rst(rst), .pixel_pulse(pixel_pulse), .col(col), .row(row),
    .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .wr_ack(wr_ack[1]), .wr_err(wr_err[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]), .mem_re(mem_re[1]),
    .mem_rdata(mem_rdata[1]), .pix_data(pix_data[1]), .pix_valid(pix_valid[1]),
    .frame_done(frame_done[1]));

  // SRAM stand-in: returns the low address byte one cycle after a read.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (mem_re[k]) mem_rdata[k] <= mem_addr[k][7:0];
  end

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] at col=%0d row=%0d observed=%h expected=%h", tag, idx, col, row, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("mem_re",     i, 32'(mem_re[i]),     32'(e_re[i]));
      chk("mem_we",     i, 32'(mem_we[i]),     32'(e_we[i]));
      chk("wr_ack",     i, 32'(wr_ack[i]),     32'(e_ack[i]));
      chk("wr_err",     i, 32'(wr_err[i]),     32'(e_err[i]));
      chk("frame_done", i, 32'(frame_done[i]), 32'(e_fd[i]));
      chk("mem_addr",   i, 32'(mem_addr[i]),   32'(e_addr[i]));
      chk("mem_wdata",  i, 32'(mem_wdata[i]),  32'(e_wdata[i]));
      chk("pix_valid",  i, 32'(pix_valid[i]),  32'(e_pv[i]));
      chk("pix_data",   i, 32'(pix_data[i]),   32'(e_pd[i]));
    end
    // A whole frame of reads must sit between consecutive frame_done pulses.
    if (mem_re[0] === 1'b1) reads_in_frame++;
    if (frame_done[0] === 1'b1) begin
      chk("reads_per_frame", 0, 32'(reads_in_frame), 32'(HV));
      reads_in_frame = 0;
    end
  endtask

  task automatic model_clear();
    running = 1'b0;
    reads_in_frame = 0;
    for (int i = 0; i < 2; i++) begin
      e_re[i] = 0; e_we[i] = 0; e_ack[i] = 0; e_err[i] = 0; e_fd[i] = 0; e_pv[i] = 0;
      e_addr[i] = '0; e_wdata[i] = '0; e_pd[i] = '0;
      re_hist[i] = 0; addr_hist[i] = '0; ack_prev[i] = 0;
      wr_req[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0;
    end
  endtask

  // Outputs expected after the coming edge, from the raster position and request.
  task automatic predict();
    bit start, act, disp, go, ok;
    int lin;
    start = pixel_pulse && col == 0 && row == 0;
    act   = (int'(col) < H) && (int'(row) < V);
    disp  = (running || start) && pixel_pulse && act;
    lin   = int'(row) * H + int'(col);
    for (int i = 0; i < 2; i++) begin
      go = !disp && wr_req[i] && !e_ack[i] && !(i == 1 && act);
      ok = int'(wr_addr[i]) < HV;
      e_pv[i] = re_hist[i];
      if (re_hist[i]) e_pd[i] = addr_hist[i][7:0];
      re_hist[i]   = e_re[i];
      addr_hist[i] = e_addr[i];
      e_re[i]  = disp;
      e_we[i]  = go && ok;
      e_ack[i] = go;
      e_err[i] = go && !ok;
      e_fd[i]  = disp && (lin == HV - 1);
      if (disp) e_addr[i] = 19'(lin);
      else if (go && ok) begin
        e_addr[i]  = wr_addr[i];
        e_wdata[i] = wr_data[i];
      end
    end
    if (start) running = 1'b1;
  endtask

  task automatic new_request(input int i);
    int sel;
    sel = $urandom_range(0, 19);
    wr_req[i]  = 1'b1;
    wr_data[i] = 8'($urandom);
    if (sel == 0)      wr_addr[i] = 19'h4B000;
    else if (sel == 1) wr_addr[i] = 19'(HV + $urandom_range(0, 3));
    else               wr_addr[i] = 19'($urandom_range(0, HV - 1));
  endtask

  // mode 0: divide-by-2 pixel pulse, 1: every cycle, 2: random
  task automatic step(input int mode);
    int c, r;
    @(negedge clk);
    check_all();
    if (pixel_pulse) begin
      c = int'(col) + 1;
      r = int'(row);
      if (c == HT) begin c = 0; r = r + 1; end
      if (r == VT) r = 0;
      col = 10'(c);
      row = 10'(r);
    end
    case (mode)
      0:       pixel_pulse = !pixel_pulse;
      1:       pixel_pulse = 1'b1;
      default: pixel_pulse = ($urandom_range(0, 2) == 0);
    endcase
    for (int i = 0; i < 2; i++) begin
      // The writer only notices an ack at the edge closing the ack cycle.
      if (ack_prev[i]) begin
        if ($urandom_range(0, 1) == 0) new_request(i);
        else wr_req[i] = 1'b0;
      end else if (!e_ack[i]) begin
        if (wr_req[i] && $urandom_range(0, 15) == 0) wr_req[i] = 1'b0;
        else if (!wr_req[i] && $urandom_range(0, 3) == 0) new_request(i);
      end
      ack_prev[i] = e_ack[i];
    end
    predict();
  endtask

  // Reset mid-frame, check outputs clear asynchronously, hold one edge.
  task automatic do_reset();
    rst = 1'b1;
    col = 10'd10;
    row = 10'd5;
    pixel_pulse = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mem_re",   i, 32'(mem_re[i]),    32'd0);
      chk("rst_mem_we",   i, 32'(mem_we[i]),    32'd0);
      chk("rst_wr_ack",   i, 32'(wr_ack[i]),    32'd0);
      chk("rst_wr_err",   i, 32'(wr_err[i]),    32'd0);
      chk("rst_mem_addr", i, 32'(mem_addr[i]),  32'd0);
      chk("rst_wdata",    i, 32'(mem_wdata[i]), 32'd0);
      chk("rst_pix",      i, 32'(pix_data[i]),  32'd0);
      chk("rst_pix_vld",  i, 32'(pix_valid[i]), 32'd0);
      chk("rst_fdone",    i, 32'(frame_done[i]),32'd0);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    predict();
  endtask

  initial begin
    rst = 1'b0;
    pixel_pulse = 1'b0;
    col = 10'd10;
    row = 10'd5;
    model_clear();
    @(negedge clk);
    do_reset();
    for (int n = 0; n < 1400; n++) step(0);
    @(negedge clk);
    check_all();
    do_reset();
    for (int n = 0; n < 700; n++) step(1);
    for (int n = 0; n < 1500; n++) step(2);
    for (int n = 0; n < 500; n++) step(0);
    @(negedge clk);
    check_all();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
